// File: rtl/conv_window_feeder.sv
// Line-buffered column feeder for a 3x3 convolution core: accepts a raster pixel
// stream, emits one (top, mid, bot) column per accepted pixel and qualifies interior windows.
module conv_window_feeder #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 64,
    parameter int IMG_HEIGHT  = 48,
    parameter int COLW        = $clog2(IMG_WIDTH),
    parameter int ROWW        = $clog2(IMG_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic [PIXEL_WIDTH-1:0] pix_top,
    output logic [PIXEL_WIDTH-1:0] pix_mid,
    output logic [PIXEL_WIDTH-1:0] pix_bot,
    output logic                   shift_en,
    output logic                   win_valid,
    output logic [ROWW-1:0]        win_row,
    output logic [COLW-1:0]        win_col,
    output logic                   busy,
    output logic                   frame_done
);

    // Handshake: a pixel transfers on a rising edge where in_valid and in_ready are both high.
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STREAM = 2'd2, DONE = 2'd3} state_t;

    state_t                 state_q, state_d;
    logic [ROWW-1:0]        r_q, r_d;
    logic [COLW-1:0]        c_q, c_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   shift_en_q, shift_en_d;
    logic                   win_valid_q, win_valid_d;
    logic [PIXEL_WIDTH-1:0] pix_top_q, pix_top_d;
    logic [PIXEL_WIDTH-1:0] pix_mid_q, pix_mid_d;
    logic [PIXEL_WIDTH-1:0] pix_bot_q, pix_bot_d;
    logic [ROWW-1:0]        win_row_q, win_row_d;
    logic [COLW-1:0]        win_col_q, win_col_d;

    logic [PIXEL_WIDTH-1:0] l0_q [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] l1_q [IMG_WIDTH];

    logic                   accept;
    logic                   last_col;
    logic [PIXEL_WIDTH-1:0] l0_rd;
    logic [PIXEL_WIDTH-1:0] l1_rd;

    assign accept   = in_valid & in_ready_q;
    assign last_col = (c_q == COLW'(IMG_WIDTH - 1));
    assign l0_rd    = l0_q[c_q];
    assign l1_rd    = l1_q[c_q];

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            FILL:    if (accept && last_col && r_q == ROWW'(1)) state_d = STREAM;
            STREAM:  if (accept && last_col && r_q == ROWW'(IMG_HEIGHT - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Row keeps counting past the last line; the FSM ends the frame instead.
        if (accept) begin
            if (last_col) begin
                c_d = '0;
                r_d = r_q + ROWW'(1);
            end else begin
                c_d = c_q + COLW'(1);
            end
        end
    end

    always_comb begin
        in_ready_d   = (state_d == FILL) || (state_d == STREAM);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
        shift_en_d   = accept;
        win_valid_d  = accept && (r_q >= ROWW'(2)) && (c_q >= COLW'(2));
        pix_top_d    = pix_top_q;
        pix_mid_d    = pix_mid_q;
        pix_bot_d    = pix_bot_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        if (accept) begin
            pix_bot_d = in_pixel;
            pix_mid_d = (r_q >= ROWW'(1)) ? l1_rd : '0;
            pix_top_d = (r_q >= ROWW'(2)) ? l0_rd : '0;
            win_row_d = r_q - ROWW'(1);
            win_col_d = c_q - COLW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            r_q          <= '0;
            c_q          <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            shift_en_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            pix_top_q    <= '0;
            pix_mid_q    <= '0;
            pix_bot_q    <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            shift_en_q   <= shift_en_d;
            win_valid_q  <= win_valid_d;
            pix_top_q    <= pix_top_d;
            pix_mid_q    <= pix_mid_d;
            pix_bot_q    <= pix_bot_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
        end
    end

    // Line memories need no reset; rows are only read once they have been written.
    always_ff @(posedge clk) begin
        if (accept) begin
            l0_q[c_q] <= l1_rd;
            l1_q[c_q] <= in_pixel;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign shift_en   = shift_en_q;
    assign win_valid  = win_valid_q;
    assign pix_top    = pix_top_q;
    assign pix_mid    = pix_mid_q;
    assign pix_bot    = pix_bot_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder on a 4x3 image: per-cycle reference of the column
// triple derived from a stored frame image, plus scenario-level constant checks.
module tb_conv_window_feeder;

    localparam int PW   = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int COLW = 2;
    localparam int ROWW = 2;
    localparam int NPIX = W * H;
    localparam int NWIN = (H - 2) * (W - 2);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [PW-1:0]   in_pixel = '0;
    logic [PW-1:0]   pix_top, pix_mid, pix_bot;
    logic            shift_en, win_valid;
    logic [ROWW-1:0] win_row;
    logic [COLW-1:0] win_col;
    logic            busy, frame_done;

    int n_cmp = 0;
    int n_fail = 0;

    logic [PW-1:0] img [H][W];

    logic [PW-1:0]   hold_top, hold_mid, hold_bot;
    logic [ROWW-1:0] hold_row;
    logic [COLW-1:0] hold_col;

    int n_shift, n_win, n_done;
    bit done_with_shift, aborted;
    logic [PW-1:0]   win1_top, win1_mid, win1_bot, win2_top, win2_mid, win2_bot;
    logic [ROWW-1:0] win1_row;
    logic [COLW-1:0] win1_col, win2_col;

    conv_window_feeder #(
        .PIXEL_WIDTH(PW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .pix_top   (pix_top),
        .pix_mid   (pix_mid),
        .pix_bot   (pix_bot),
        .shift_en  (shift_en),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic fill_pattern(input int base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = PW'(base + 16 * r + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = PW'($urandom);
    endtask

    // Drives one frame; every cycle compares the DUT against the image-derived reference.
    task automatic run_frame(input bit rand_valid, input bit poke_start, input int abort_after);
        int acc;
        bit prev_acc, prev_last, finished, v, exp_win;
        int pr, pc;
        n_shift = 0; n_win = 0; n_done = 0; done_with_shift = 0; aborted = 0;
        @(negedge clk); start = 1'b1; in_valid = 1'b0;
        @(negedge clk); start = 1'b0;
        acc = 0; prev_acc = 0; prev_last = 0; finished = 0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (shift_en === 1'b1) n_shift++;
            if (win_valid === 1'b1) begin
                n_win++;
                if (n_win == 1) begin
                    win1_top = pix_top; win1_mid = pix_mid; win1_bot = pix_bot;
                    win1_row = win_row; win1_col = win_col;
                end else if (n_win == 2) begin
                    win2_top = pix_top; win2_mid = pix_mid; win2_bot = pix_bot;
                    win2_col = win_col;
                end
            end
            if (frame_done === 1'b1) begin
                n_done++;
                if (shift_en === 1'b1) done_with_shift = 1;
            end
            exp_win = 0;
            if (prev_acc) begin
                pr = (acc - 1) / W;
                pc = (acc - 1) % W;
                hold_bot = img[pr][pc];
                hold_mid = (pr >= 1) ? img[pr-1][pc] : '0;
                hold_top = (pr >= 2) ? img[pr-2][pc] : '0;
                hold_row = ROWW'(pr - 1);
                hold_col = COLW'(pc - 1);
                exp_win  = (pr >= 2) && (pc >= 2);
            end
            n_cmp++; if (in_ready !== (acc < NPIX)) begin n_fail++; $display("FAIL in_ready acc=%0d got %b exp %b", acc, in_ready, acc < NPIX); end
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_frame acc=%0d got %b exp 1", acc, busy); end
            n_cmp++; if (frame_done !== prev_last) begin n_fail++; $display("FAIL frame_done acc=%0d got %b exp %b", acc, frame_done, prev_last); end
            n_cmp++; if (shift_en !== prev_acc) begin n_fail++; $display("FAIL shift_en acc=%0d got %b exp %b", acc, shift_en, prev_acc); end
            n_cmp++; if (win_valid !== exp_win) begin n_fail++; $display("FAIL win_valid acc=%0d got %b exp %b", acc, win_valid, exp_win); end
            n_cmp++; if (pix_top !== hold_top) begin n_fail++; $display("FAIL pix_top acc=%0d got %h exp %h", acc, pix_top, hold_top); end
            n_cmp++; if (pix_mid !== hold_mid) begin n_fail++; $display("FAIL pix_mid acc=%0d got %h exp %h", acc, pix_mid, hold_mid); end
            n_cmp++; if (pix_bot !== hold_bot) begin n_fail++; $display("FAIL pix_bot acc=%0d got %h exp %h", acc, pix_bot, hold_bot); end
            n_cmp++; if (win_row !== hold_row) begin n_fail++; $display("FAIL win_row acc=%0d got %0d exp %0d", acc, win_row, hold_row); end
            n_cmp++; if (win_col !== hold_col) begin n_fail++; $display("FAIL win_col acc=%0d got %0d exp %0d", acc, win_col, hold_col); end

            if (prev_last) begin
                finished = 1;
            end else if (abort_after >= 0 && acc == abort_after + 1) begin
                rst = 1'b1; in_valid = 1'b1;
                @(negedge clk); rst = 1'b0;
                hold_top = '0; hold_mid = '0; hold_bot = '0; hold_row = '0; hold_col = '0;
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy); end
                n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_in_ready got %b exp 0", in_ready); end
                n_cmp++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL abort_shift_en got %b exp 0", shift_en); end
                n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL abort_frame_done got %b exp 0", frame_done); end
                n_cmp++; if (pix_bot !== '0) begin n_fail++; $display("FAIL abort_pix_bot got %h exp 00", pix_bot); end
                aborted = 1;
                finished = 1;
            end else begin
                v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                in_valid = v;
                in_pixel = (v && acc < NPIX) ? img[acc / W][acc % W] : PW'($urandom);
                start = poke_start && (acc == 2 * W + 1);
                prev_acc  = v && (acc < NPIX);
                prev_last = prev_acc && (acc == NPIX - 1);
                if (prev_acc) acc++;
                @(negedge clk);
            end
        end
        n_cmp++; if (!finished) begin n_fail++; $display("FAIL frame_timeout acc=%0d exp %0d", acc, NPIX); end
        if (poke_start && finished && !aborted) begin
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_busy got %b exp 0", busy); end
            n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL done_start_frame_done got %b exp 0", frame_done); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_pixel = PW'($urandom);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold_top = '0; hold_mid = '0; hold_bot = '0; hold_row = '0; hold_col = '0;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_cmp++; if (shift_en !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_strobes got %b%b%b exp 000", shift_en, win_valid, frame_done); end
        n_cmp++; if (pix_top !== '0 || pix_mid !== '0 || pix_bot !== '0) begin n_fail++; $display("FAIL rst_pix got %h %h %h exp 00 00 00", pix_top, pix_mid, pix_bot); end
        n_cmp++; if (win_row !== '0 || win_col !== '0) begin n_fail++; $display("FAIL rst_win got %0d %0d exp 0 0", win_row, win_col); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0 || shift_en !== 1'b0) begin n_fail++; $display("FAIL idle_hold got %b%b%b exp 000", in_ready, busy, shift_en); end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_pattern_frame(input string tag, input int base);
        n_cmp++; if (n_shift != NPIX) begin n_fail++; $display("FAIL %s shift_count got %0d exp %0d", tag, n_shift, NPIX); end
        n_cmp++; if (n_win != NWIN) begin n_fail++; $display("FAIL %s win_count got %0d exp %0d", tag, n_win, NWIN); end
        n_cmp++; if (n_done != 1 || !done_with_shift) begin n_fail++; $display("FAIL %s frame_done got %0d/%b exp 1/1", tag, n_done, done_with_shift); end
        n_cmp++; if (win1_top !== PW'(base + 8'h02) || win1_mid !== PW'(base + 8'h12) || win1_bot !== PW'(base + 8'h22)) begin
            n_fail++; $display("FAIL %s win1_pix got %h %h %h exp %h %h %h", tag, win1_top, win1_mid, win1_bot, PW'(base + 2), PW'(base + 18), PW'(base + 34)); end
        n_cmp++; if (win1_row !== 2'd1 || win1_col !== 2'd1) begin n_fail++; $display("FAIL %s win1_pos got %0d,%0d exp 1,1", tag, win1_row, win1_col); end
        n_cmp++; if (win2_top !== PW'(base + 8'h03) || win2_mid !== PW'(base + 8'h13) || win2_bot !== PW'(base + 8'h23) || win2_col !== 2'd2) begin
            n_fail++; $display("FAIL %s win2 got %h %h %h col %0d exp %h %h %h col 2", tag, win2_top, win2_mid, win2_bot, win2_col, PW'(base + 3), PW'(base + 19), PW'(base + 35)); end
    endtask

    task automatic test_full_frame();
        fill_pattern(0);
        run_frame(0, 0, -1);
        check_pattern_frame("full_frame", 0);
    endtask

    task automatic test_random_valid();
        fill_pattern(0);
        run_frame(1, 0, -1);
        check_pattern_frame("random_valid", 0);
    endtask

    task automatic test_random_pixels();
        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_frame(1, 0, -1);
            n_cmp++; if (n_win != NWIN || n_shift != NPIX) begin n_fail++; $display("FAIL random_pixels counts got %0d/%0d exp %0d/%0d", n_win, n_shift, NWIN, NPIX); end
        end
    endtask

    task automatic test_abort();
        fill_pattern(0);
        run_frame(0, 0, 2 * W + 1);
        n_cmp++; if (!aborted || n_done != 0) begin n_fail++; $display("FAIL abort_flow got %b/%0d exp 1/0", aborted, n_done); end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (frame_done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b%b exp 00", frame_done, busy); end
        end
        run_frame(0, 0, -1);
        check_pattern_frame("after_abort", 0);
    endtask

    task automatic test_start_ignored();
        fill_pattern(0);
        run_frame(1, 1, -1);
        check_pattern_frame("start_ignored", 0);
    endtask

    task automatic test_back_to_back();
        fill_pattern(0);
        run_frame(0, 0, -1);
        check_pattern_frame("b2b_first", 0);
        fill_pattern(8'h80);
        run_frame(0, 0, -1);
        check_pattern_frame("b2b_second", 8'h80);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_valid();
        test_random_pixels();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
